// File: rtl/edge_gen_pkg.sv
// edge_gen_pkg: shared types and helpers for the edge pulse generator.
//   state_e    - run FSM states
//   CNT_W_DEF  - default phase-length field width
//   NUM_W_DEF  - default pulse-count field width
//   min_one()  - maps a zero-length phase to one cycle
package edge_gen_pkg;

  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned NUM_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    DONE
  } state_e;

  function automatic int unsigned min_one(input int unsigned len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/edge_gen_timer.sv
// edge_gen_timer: loadable down-counter timing one phase of the pulse train.
//   clk_i    - clock
//   rst_i    - synchronous active-high reset
//   load_i   - load value_i into the counter at this edge
//   value_i  - phase length in cycles (>= 1)
//   expire_o - high during the last cycle of the loaded phase
module edge_gen_timer
  import edge_gen_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts down to zero and parks there, so it never wraps while idle.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A phase loaded with v lasts v cycles: the state change happens at the
  // edge where the counter holds 1.
  assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/edge_pulse_gen.sv
// edge_pulse_gen: programmable pulse-train generator with rise/fall strobes.
//   clk, rst                     - clock, synchronous active-high reset
//   start, abort                 - run request (IDLE only) / cancel
//   high_cyc, low_cyc, num_pulses - run configuration, captured on accept
//   pulse_out                    - generated waveform
//   rise_stb, fall_stb           - one-cycle strobes after each transition
//   busy, done                   - run in progress / one-cycle completion
//   pulse_cnt                    - rising edges of the current or last run
module edge_pulse_gen
  import edge_gen_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned NUM_W = NUM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] high_cyc,
  input  logic [CNT_W-1:0] low_cyc,
  input  logic [NUM_W-1:0] num_pulses,
  input  logic             abort,
  output logic             pulse_out,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] pulse_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] h_q, h_d, l_q, l_d;
  logic [NUM_W-1:0] n_q, n_d, cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_expire;
  logic [CNT_W-1:0] h_in, l_in;

  assign h_in = CNT_W'(min_one(32'(high_cyc)));
  assign l_in = CNT_W'(min_one(32'(low_cyc)));

  edge_gen_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .expire_o(tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    l_d       = l_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    pulse_d   = pulse_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = h_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          h_d   = h_in;
          l_d   = l_in;
          n_d   = num_pulses;
          cnt_d = '0;
          if (num_pulses == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = HIGH;
            pulse_d   = 1'b1;
            rise_d    = 1'b1;
            busy_d    = 1'b1;
            cnt_d     = NUM_W'(1);
            tmr_load  = 1'b1;
            tmr_value = h_in;
          end
        end
      end
      HIGH: begin
        if (abort) begin
          state_d = IDLE;
          pulse_d = 1'b0;
          fall_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (tmr_expire) begin
          state_d   = LOW;
          pulse_d   = 1'b0;
          fall_d    = 1'b1;
          tmr_load  = 1'b1;
          tmr_value = l_q;
        end
      end
      LOW: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (tmr_expire) begin
          if (cnt_q < n_q) begin
            state_d   = HIGH;
            pulse_d   = 1'b1;
            rise_d    = 1'b1;
            cnt_d     = cnt_q + NUM_W'(1);
            tmr_load  = 1'b1;
            tmr_value = h_q;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      h_q     <= '0;
      l_q     <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      l_q     <= l_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pulse_out = pulse_q;
  assign rise_stb  = rise_q;
  assign fall_stb  = fall_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_cnt = cnt_q;

endmodule
